hazard_scoreboard: RTL

//  Next-generation DEC-stage hazard unit for the RISC-V core: parametrised operand bypass over NFWD

---
 rtl/rv_hazard_pkg.sv | 17 +
 rtl/hazard_fwd_port.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv_hazard_pkg.sv
// Shared types for the DEC-stage hazard unit: register address width, x0 and stall-reason encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv_hazard_pkg;

    localparam int REG_W = 5;
    localparam int NREGS = 1 << REG_W;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOAD = 2'd1,
        CSR  = 2'd2,
        LL   = 2'd3
    } stall_reason_e;

endpackage

// File: rtl/hazard_fwd_port.sv
// One DEC source port: youngest-first bypass mux, LL-return capture and stall cause.
// Latency: purely combinational.
// Backpressure: reports a stall reason; the caller qualifies it with dec_valid.
module hazard_fwd_port
    import rv_hazard_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 3
) (
    input  logic [REG_W-1:0]      rs,
    input  logic                  renb,
    input  logic [XLEN-1:0]       rdata,
    input  logic [NFWD*REG_W-1:0] fwd_rd,
    input  logic [NFWD-1:0]       fwd_wenb,
    input  logic [NFWD-1:0]       fwd_late,
    input  logic [NFWD-1:0]       fwd_csr,
    input  logic [NFWD*XLEN-1:0]  fwd_result,
    input  logic                  ll_done,
    input  logic [REG_W-1:0]      ll_done_rd,
    input  logic [XLEN-1:0]       ll_result,
    input  logic [NREGS-1:0]      pending,
    output logic [XLEN-1:0]       data,
    output stall_reason_e         reason
);

    logic hit;

    always_comb begin
        data   = rdata;
        reason = NONE;
        hit    = 1'b0;
        if (renb && rs != REG_ZERO) begin
            // Stage 0 is the youngest, so the first match carries the newest value.
            for (int i = 0; i < NFWD; i++) begin
                if (!hit && fwd_wenb[i] && fwd_rd[i*REG_W +: REG_W] == rs) begin
                    hit = 1'b1;
                    if (fwd_late[i]) begin
                        reason = fwd_csr[i] ? CSR : LOAD;
                    end else begin
                        data = fwd_result[i*XLEN +: XLEN];
                    end
                end
            end
            if (!hit) begin
                if (ll_done && ll_done_rd == rs) begin
                    data = ll_result;
                end else if (pending[rs]) begin
                    reason = LL;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// DEC hazard unit: per-port bypass, long-latency register scoreboard and saturating stall counter.
// Latency: stall/operands combinational; scoreboard, ll_busy and stall_cycles update on the next edge.
// Backpressure: dec_stall holds DEC; LL issue/done must respect the MAX_LL outstanding limit.
module hazard_scoreboard
    import rv_hazard_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NRS    = 2,
    parameter int NFWD   = 3,
    parameter int MAX_LL = 4,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [NRS*REG_W-1:0]  dec_rs,
    input  logic [NRS-1:0]        dec_rs_renb,
    input  logic [NRS*XLEN-1:0]   dec_rdata,
    input  logic [REG_W-1:0]      dec_rd,
    input  logic                  dec_rd_wenb,
    input  logic                  dec_ll,
    input  logic [NFWD*REG_W-1:0] fwd_rd,
    input  logic [NFWD-1:0]       fwd_wenb,
    input  logic [NFWD-1:0]       fwd_late,
    input  logic [NFWD-1:0]       fwd_csr,
    input  logic [NFWD*XLEN-1:0]  fwd_result,
    input  logic                  ll_issue,
    input  logic [REG_W-1:0]      ll_issue_rd,
    input  logic                  ll_done,
    input  logic [REG_W-1:0]      ll_done_rd,
    input  logic [XLEN-1:0]       ll_result,
    output logic                  dec_stall,
    output logic                  dec_load_use,
    output logic                  dec_csr_use,
    output logic                  dec_ll_use,
    output logic [NRS*XLEN-1:0]   dec_rs_data,
    output logic                  ll_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int LLC_W = $clog2(MAX_LL + 1);
    localparam logic [LLC_W-1:0] LL_MAX = LLC_W'(MAX_LL);

    logic [NREGS-1:0] pending, pending_nxt;
    logic [LLC_W-1:0] ll_cnt, ll_cnt_nxt;
    stall_reason_e    port_reason [NRS];
    logic             any_load, any_csr, any_rs_ll, waw, full;

    for (genvar p = 0; p < NRS; p++) begin : g_port
        hazard_fwd_port #(.XLEN(XLEN), .NFWD(NFWD)) u_port (
            .rs         (dec_rs[p*REG_W +: REG_W]),
            .renb       (dec_rs_renb[p]),
            .rdata      (dec_rdata[p*XLEN +: XLEN]),
            .fwd_rd     (fwd_rd),
            .fwd_wenb   (fwd_wenb),
            .fwd_late   (fwd_late),
            .fwd_csr    (fwd_csr),
            .fwd_result (fwd_result),
            .ll_done    (ll_done),
            .ll_done_rd (ll_done_rd),
            .ll_result  (ll_result),
            .pending    (pending),
            .data       (dec_rs_data[p*XLEN +: XLEN]),
            .reason     (port_reason[p])
        );
    end

    always_comb begin
        any_load  = 1'b0;
        any_csr   = 1'b0;
        any_rs_ll = 1'b0;
        for (int p = 0; p < NRS; p++) begin
            any_load  |= (port_reason[p] == LOAD);
            any_csr   |= (port_reason[p] == CSR);
            any_rs_ll |= (port_reason[p] == LL);
        end
        // A returning LL result for the same rd retires the older write in time.
        waw = dec_rd_wenb && dec_rd != REG_ZERO && pending[dec_rd]
              && !(ll_done && ll_done_rd == dec_rd);
        full = dec_ll && ll_cnt == LL_MAX && !ll_done;
    end

    assign dec_load_use = dec_valid && any_load;
    assign dec_csr_use  = dec_valid && any_csr;
    assign dec_ll_use   = dec_valid && (any_rs_ll || waw || full);
    assign dec_stall    = dec_load_use || dec_csr_use || dec_ll_use;

    always_comb begin
        pending_nxt = pending;
        if (ll_done)  pending_nxt[ll_done_rd]  = 1'b0;
        if (ll_issue) pending_nxt[ll_issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;

        ll_cnt_nxt = ll_cnt;
        if (ll_issue && !ll_done && ll_cnt != LL_MAX) begin
            ll_cnt_nxt = ll_cnt + LLC_W'(1);
        end else if (ll_done && !ll_issue && ll_cnt != '0) begin
            ll_cnt_nxt = ll_cnt - LLC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            ll_cnt       <= '0;
            ll_busy      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            pending <= pending_nxt;
            ll_cnt  <= ll_cnt_nxt;
            ll_busy <= (ll_cnt_nxt != '0);
            if (dec_stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    ll_cnt_protocol: assert property (@(posedge clk) disable iff (reset)
        !(ll_issue && !ll_done && ll_cnt == LL_MAX) && !(ll_done && !ll_issue && ll_cnt == '0));

endmodule
